synff_arbiter: RTL and testbench

Write-side arbiter and occupancy controller for the `synff` synchronous FIFO. It shares the FIFO's single write port among NREQ producers using round-robin priority. It gates consumer read requests against an internally tracked occupancy count, because `synff` exposes no full/empty flags. It sits directly in front of `synff` and drives `din`, `wr_en` and `rd_en`.

---
 rtl/synff_pkg.sv | 16 +
 rtl/synff_arbiter_rr.sv | 45 ++++
 rtl/synff_arbiter.sv | 70 +++++++
 tb/tb_synff_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/synff_pkg.sv
// Shared defaults, type and width helpers for the synff write arbiter.
package synff_pkg;

   localparam int WIDTH_DEFAULT = 8;
   localparam int NREQ_DEFAULT  = 4;
   localparam int DEPTH_DEFAULT = 16;
   localparam int GRANT_W       = $clog2(NREQ_DEFAULT);

   typedef logic [GRANT_W-1:0] grant_idx_t;

   // Occupancy must represent 0..depth inclusive.
   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/synff_arbiter_rr.sv
// Round-robin arbiter: searches from ptr upward (wrapping), owns ptr.
module rr_arbiter
   import synff_pkg::*;
#(
   parameter  int NREQ = NREQ_DEFAULT,
   localparam int IW   = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            enable,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   grant_idx
);

   logic [IW-1:0] ptr;
   logic          found;
   int            j;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      j         = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (enable && !found && req[j]) begin
            found     = 1'b1;
            grant[j]  = 1'b1;
            grant_idx = IW'(j);
         end
      end
   end

   // The winner drops to lowest priority; ptr holds when nothing is granted.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (|grant) begin
         ptr <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/synff_arbiter.sv
// Front end for synff: arbitrates producers onto the write port and gates
// reads against a locally tracked occupancy, since synff has no flags.
module synff_arbiter
   import synff_pkg::*;
#(
   parameter  int WIDTH = WIDTH_DEFAULT,
   parameter  int NREQ  = NREQ_DEFAULT,
   parameter  int DEPTH = DEPTH_DEFAULT,
   localparam int GW    = $clog2(NREQ),
   localparam int CW    = count_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic [GW-1:0]         grant_id,
   output logic [WIDTH-1:0]      fifo_din,
   output logic                  fifo_wr_en,
   output logic                  fifo_rd_en,
   input  logic                  rd_req,
   output logic                  rd_valid,
   output logic [CW-1:0]         count,
   output logic                  full,
   output logic                  empty
);

   // Handshake: producer i's word is taken on the rising edge where
   // req_valid[i] && req_ready[i]; a waiting producer keeps req_data stable.
   logic grant_en;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign grant_en = !rst && !full;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .clk       (clk),
      .rst       (rst),
      .req       (req_valid),
      .enable    (grant_en),
      .grant     (req_ready),
      .grant_idx (grant_id)
   );

   assign fifo_wr_en = |req_ready;
   assign fifo_rd_en = rd_req && !empty && !rst;

   always_comb begin
      fifo_din = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req_ready[i]) fifo_din = req_data[i*WIDTH +: WIDTH];
      end
   end

   // A simultaneous read and write cancel out.
   always_ff @(posedge clk) begin
      if (rst) begin
         count    <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= fifo_rd_en;
         case ({fifo_wr_en, fifo_rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_synff_arbiter.sv
// Directed bench for synff_arbiter with a behavioural synff behind it.
module tb_synff_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic [1:0]  grant_id;
   logic [7:0]  fifo_din;
   logic        fifo_wr_en;
   logic        fifo_rd_en;
   logic        rd_req;
   logic        rd_valid;
   logic [4:0]  count;
   logic        full;
   logic        empty;

   int tests = 0;
   int fails = 0;

   logic [7:0] exp_q[$];
   logic [7:0] drain_q[$];
   logic [7:0] mem_q[$];
   logic [7:0] dout;

   always #5 clk = ~clk;

   synff_arbiter #(.WIDTH(8), .NREQ(4), .DEPTH(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .grant_id   (grant_id),
      .fifo_din   (fifo_din),
      .fifo_wr_en (fifo_wr_en),
      .fifo_rd_en (fifo_rd_en),
      .rd_req     (rd_req),
      .rd_valid   (rd_valid),
      .count      (count),
      .full       (full),
      .empty      (empty)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Behavioural synff: registered dout, cleared by the shared reset.
   always @(posedge clk) begin
      if (rst) begin
         mem_q.delete();
         dout <= '0;
      end else begin
         if (fifo_rd_en && mem_q.size() > 0) dout <= mem_q.pop_front();
         if (fifo_wr_en) mem_q.push_back(fifo_din);
      end
   end

   always @(negedge clk) begin
      if (rst === 1'b0 && fifo_wr_en === 1'b1) begin
         if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
         else chk("write_data", fifo_din, exp_q.pop_front());
      end
      if (rst === 1'b0 && rd_valid === 1'b1) begin
         if (drain_q.size() == 0) chk("unexpected_rd_valid", 1, 0);
         else chk("drain_data", dout, drain_q.pop_front());
      end
   end

   initial begin
      rst       = 1'b1;
      req_valid = 4'hF;
      req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
      rd_req    = 1'b1;
      #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_wr_en", fifo_wr_en, 0);
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_din", fifo_din, 0);
      tick();
      tick();
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_rd_valid", rd_valid, 0);
      rst    = 1'b0;
      rd_req = 1'b0;

      // Fill with all producers requesting.
      for (int c = 0; c < 16; c++) begin
         #1;
         chk("fill_grant_id", grant_id, c % 4);
         chk("fill_req_ready", req_ready, 32'd1 << (c % 4));
         exp_q.push_back(8'h10 + 8'(c % 4));
         tick();
      end
      #1;
      chk("full_flag", full, 1);
      chk("full_count", count, 16);
      chk("full_req_ready", req_ready, 0);
      chk("full_wr_en", fifo_wr_en, 0);

      // Read at full with writers waiting: read only.
      rd_req = 1'b1;
      #1;
      chk("full_rd_en", fifo_rd_en, 1);
      chk("full_no_write", fifo_wr_en, 0);
      drain_q.push_back(8'h10);
      tick();
      chk("full_read_count", count, 15);
      chk("full_read_flag", full, 0);

      req_valid = 4'h0;
      for (int k = 1; k < 16; k++) begin
         #1;
         chk("drain_rd_en", fifo_rd_en, 1);
         drain_q.push_back(8'h10 + 8'(k % 4));
         tick();
      end
      chk("drain_count", count, 0);
      chk("drain_empty", empty, 1);

      // Empty read with a write in the same cycle.
      req_valid = 4'b0001;
      #1;
      chk("empty_rd_en", fifo_rd_en, 0);
      chk("empty_wr_en", fifo_wr_en, 1);
      chk("empty_grant", grant_id, 0);
      exp_q.push_back(8'h10);
      tick();
      chk("empty_count", count, 1);
      chk("empty_rd_valid", rd_valid, 0);
      rd_req = 1'b0;

      // Walk ptr to 3, then a lone request from producer 1.
      req_valid = 4'b0010; #1; chk("walk_grant1", grant_id, 1); exp_q.push_back(8'h11); tick();
      req_valid = 4'b0100; #1; chk("walk_grant2", grant_id, 2); exp_q.push_back(8'h12); tick();
      req_valid = 4'b0010; #1; chk("sparse_grant", grant_id, 1); exp_q.push_back(8'h11); tick();
      req_valid = 4'b0111; #1; chk("sparse_ptr2", grant_id, 2); exp_q.push_back(8'h12); tick();
      chk("sparse_count", count, 5);

      // Simultaneous read and write mid-range.
      req_valid = 4'b0001;
      rd_req    = 1'b1;
      #1;
      chk("simul_grant", grant_id, 0);
      chk("simul_wr_en", fifo_wr_en, 1);
      chk("simul_rd_en", fifo_rd_en, 1);
      exp_q.push_back(8'h10);
      drain_q.push_back(8'h10);
      tick();
      chk("simul_count", count, 5);
      chk("simul_rd_valid", rd_valid, 1);
      rd_req = 1'b0;

      // Reach count 7 with ptr 2, then reset mid-operation.
      req_valid = 4'b0010; #1; chk("pre_rst_grant_a", grant_id, 1); exp_q.push_back(8'h11); tick();
      req_valid = 4'b0010; #1; chk("pre_rst_grant_b", grant_id, 1); exp_q.push_back(8'h11); tick();
      chk("pre_rst_count", count, 7);
      rst       = 1'b1;
      req_valid = 4'hF;
      #1;
      chk("midrst_req_ready", req_ready, 0);
      chk("midrst_din", fifo_din, 0);
      tick();
      rst = 1'b0;
      #1;
      chk("post_rst_count", count, 0);
      chk("post_rst_empty", empty, 1);
      chk("post_rst_grant", grant_id, 0);
      exp_q.push_back(8'h10);
      tick();
      req_valid = 4'h0;
      tick();
      tick();
      chk("exp_q_drained", exp_q.size(), 0);
      chk("drain_q_drained", drain_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
